multicycle_control_unit: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 60 ++++++
 rtl/alu_decoder.sv | 34 +++
 rtl/multicycle_control_unit.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Holds state encoding, opcode/funct values, ALUOp and ALU control codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_INTR   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef struct packed {
        alu_op_t    alu_op;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       is_branch;
        logic       lor_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       is_interrupted;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: (ALUOp, funct) -> aluControl.
// Ports: alu_op, funct in; alu_control, funct_legal (R-type funct known) out.
module alu_decoder (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [1:0] alu_control,
    output logic       funct_legal
);
    import mips_ctrl_pkg::*;

    logic [1:0] r_code;

    always_comb begin
        r_code      = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_ADD:  r_code = ALU_ADD;
            FN_SUB:  r_code = ALU_SUB;
            FN_AND:  r_code = ALU_AND;
            FN_OR:   r_code = ALU_OR;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (alu_op_t'(alu_op))
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = r_code;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS core, with irq latching
// and sticky illegal-instruction flag.
// Ports: clk, reset (sync, high), op, funct, irq in; datapath strobes,
// mux selects, aluControl, illegal_op, dbg_state out.
module multicycle_control_unit #(
    parameter bit VECTOR_EN = 1'b1,
    parameter int STATE_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               irq,
    output logic [1:0]         aluControl,
    output logic [1:0]         aluSrcB,
    output logic               ALUSrcA,
    output logic [1:0]         PCSource,
    output logic               PCWrite,
    output logic               isBranch,
    output logic               lorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               isInterrupted,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);
    import mips_ctrl_pkg::*;

    state_t state_q, state_d;
    state_t ret_state;
    logic   pending_q, pending_d;
    logic   illegal_q, illegal_d;
    logic   funct_legal;
    ctrl_t  ctrl, ctrl_o;

    // End of an instruction: vector fetch if an irq has been latched.
    assign ret_state = (VECTOR_EN && pending_q) ? S_INTR : S_FETCH;

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH, S_INTR: state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW)
                    state_d = S_MEMADR;
                else if (op == OP_RTYPE && funct_legal)
                    state_d = S_EXEC;
                else if (op == OP_BEQ)
                    state_d = S_BRANCH;
                else if (op == OP_ADDI)
                    state_d = S_ADDIEX;
                else if (op == OP_J)
                    state_d = S_JUMP;
                else begin
                    state_d   = ret_state;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR:
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB,
            S_ADDIWB, S_BRANCH, S_JUMP:
                state_d = ret_state;
            default:  state_d = S_FETCH;
        endcase
    end

    // A new irq wins over the clear done by the INTR cycle.
    always_comb begin
        pending_d = 1'b0;
        if (VECTOR_EN)
            pending_d = irq | (pending_q & (state_q != S_INTR));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pending_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALUOP_ADD;
        case (state_q)
            S_FETCH, S_INTR: begin
                ctrl.ir_write       = 1'b1;
                ctrl.alu_src_b      = 2'b01;
                ctrl.pc_write       = 1'b1;
                ctrl.is_interrupted = (state_q == S_INTR);
            end
            S_DECODE: ctrl.alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD: ctrl.lor_d = 1'b1;
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.lor_d     = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = 2'b01;
                ctrl.is_branch = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = 2'b10;
                ctrl.pc_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Outputs are held low for the whole time reset is high,
    // including before the first clock edge.
    assign ctrl_o = reset ? '0 : ctrl;

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl_o.alu_op),
        .funct       (funct),
        .alu_control (aluControl),
        .funct_legal (funct_legal)
    );

    assign aluSrcB       = ctrl_o.alu_src_b;
    assign ALUSrcA       = ctrl_o.alu_src_a;
    assign PCSource      = ctrl_o.pc_source;
    assign PCWrite       = ctrl_o.pc_write;
    assign isBranch      = ctrl_o.is_branch;
    assign lorD          = ctrl_o.lor_d;
    assign MemWrite      = ctrl_o.mem_write;
    assign IRWrite       = ctrl_o.ir_write;
    assign RegWrite      = ctrl_o.reg_write;
    assign RegDst        = ctrl_o.reg_dst;
    assign MemtoReg      = ctrl_o.mem_to_reg;
    assign isInterrupted = ctrl_o.is_interrupted;
    assign illegal_op    = illegal_q & ~reset;
    assign dbg_state     = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against an
// instruction-level model (class -> list of micro-steps).
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       irq;
    logic [1:0] aluControl, aluSrcB, PCSource;
    logic       ALUSrcA, PCWrite, isBranch, lorD, MemWrite, IRWrite;
    logic       RegWrite, RegDst, MemtoReg, isInterrupted, illegal_op;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .irq(irq),
        .aluControl(aluControl), .aluSrcB(aluSrcB), .ALUSrcA(ALUSrcA),
        .PCSource(PCSource), .PCWrite(PCWrite), .isBranch(isBranch),
        .lorD(lorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .isInterrupted(isInterrupted), .illegal_op(illegal_op),
        .dbg_state(dbg_state)
    );

    wire [15:0] dut_vec = {aluControl, aluSrcB, ALUSrcA, PCSource,
                           PCWrite, isBranch, lorD, MemWrite, IRWrite,
                           RegWrite, RegDst, MemtoReg, isInterrupted};

    typedef enum {T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB,
                  T_MEMWR, T_EXEC, T_ALUWB, T_ADDIEX, T_ADDIWB,
                  T_BRANCH, T_JUMP, T_INTR} step_t;
    typedef enum {C_LW, C_SW, C_R, C_ADDI, C_BEQ, C_J, C_ILL} cls_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic cls_t classify(logic [5:0] o, logic [5:0] f);
        case (o)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
            6'b000000: begin
                if (f == 6'b100000 || f == 6'b100010 ||
                    f == 6'b100100 || f == 6'b100101)
                    return C_R;
                return C_ILL;
            end
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [1:0] rcode(logic [5:0] f);
        case (f)
            6'b100010: return 2'b01;
            6'b100100: return 2'b10;
            6'b100101: return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic [15:0] exp_vec(step_t s, logic [5:0] f);
        logic [1:0] alu, srcb, pcs;
        logic srca, pcw, br, lord, mw, irw, rw, rd, m2r, intr;
        {alu, srcb, pcs, srca, pcw, br, lord, mw, irw, rw, rd, m2r, intr} = '0;
        case (s)
            T_FETCH, T_INTR: begin
                irw = 1; srcb = 2'b01; pcw = 1; intr = (s == T_INTR);
            end
            T_DECODE: srcb = 2'b11;
            T_MEMADR, T_ADDIEX: begin srca = 1; srcb = 2'b10; end
            T_MEMRD: lord = 1;
            T_MEMWB: begin m2r = 1; rw = 1; end
            T_MEMWR: begin lord = 1; mw = 1; end
            T_EXEC: begin srca = 1; alu = rcode(f); end
            T_ALUWB: begin rd = 1; rw = 1; end
            T_ADDIWB: rw = 1;
            T_BRANCH: begin srca = 1; alu = 2'b01; pcs = 2'b01; br = 1; end
            T_JUMP: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {alu, srcb, srca, pcs, pcw, br, lord, mw, irw, rw, rd, m2r, intr};
    endfunction

    step_t steps[$];
    step_t cur, old;
    cls_t  cls;
    bit    pend, ill, mid_done;
    int    r;

    task automatic rst_zero_chk(input string tag);
        chk({tag, "_out"}, 32'(dut_vec), 32'd0);
        chk({tag, "_dbg"}, 32'(dbg_state), 32'd0);
        chk({tag, "_ill"}, 32'(illegal_op), 32'd0);
    endtask

    initial begin
        reset = 1'b1; op = '0; funct = '0; irq = 1'b0;
        mid_done = 0;
        repeat (3) begin
            @(negedge clk);
            rst_zero_chk("rst");
        end
        @(posedge clk);
        #1 reset = 1'b0;
        cur = T_FETCH; pend = 0; ill = 0; cls = C_ILL;
        steps.delete();

        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk("outs", 32'(dut_vec), 32'(exp_vec(cur, funct)));
            chk("illegal", 32'(illegal_op), 32'(ill));

            if (!mid_done && cyc > 400 && cur == T_MEMRD) begin
                mid_done = 1;
                reset = 1'b1;
                irq   = 1'b1;
                #1 rst_zero_chk("rmid");
                @(posedge clk);
                @(negedge clk);
                rst_zero_chk("rmid2");
                irq = 1'b0;
                @(posedge clk);
                #1 reset = 1'b0;
                cur = T_FETCH; pend = 0; ill = 0;
                steps.delete();
                continue;
            end

            if (cur == T_FETCH || cur == T_INTR) begin
                r = $urandom_range(0, 9);
                funct = 6'($urandom);
                case (r)
                    0, 9: op = 6'b100011;
                    1: op = 6'b101011;
                    2, 3: begin
                        op = 6'b000000;
                        case ($urandom_range(0, 3))
                            0: funct = 6'b100000;
                            1: funct = 6'b100010;
                            2: funct = 6'b100100;
                            default: funct = 6'b100101;
                        endcase
                    end
                    4: op = 6'b000100;
                    5: op = 6'b001000;
                    6: op = 6'b000010;
                    7: op = 6'b000000;
                    default: op = 6'($urandom);
                endcase
                cls = classify(op, funct);
                steps.push_back(T_DECODE);
                case (cls)
                    C_LW:   begin steps.push_back(T_MEMADR);
                                  steps.push_back(T_MEMRD);
                                  steps.push_back(T_MEMWB); end
                    C_SW:   begin steps.push_back(T_MEMADR);
                                  steps.push_back(T_MEMWR); end
                    C_R:    begin steps.push_back(T_EXEC);
                                  steps.push_back(T_ALUWB); end
                    C_ADDI: begin steps.push_back(T_ADDIEX);
                                  steps.push_back(T_ADDIWB); end
                    C_BEQ:  steps.push_back(T_BRANCH);
                    C_J:    steps.push_back(T_JUMP);
                    default: ;
                endcase
            end

            irq = ($urandom_range(0, 5) == 0);

            @(posedge clk);
            old = cur;
            if (old == T_DECODE && cls == C_ILL)
                ill = 1;
            if (steps.size() > 0)
                cur = steps.pop_front();
            else
                cur = pend ? T_INTR : T_FETCH;
            pend = irq | (pend & (old != T_INTR));
        end

        chk("rst_mid_hit", 32'(mid_done), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
